riscv_divider: RTL

RISCV_DIVIDER -- requirements
Module: riscv_divider

---
 rtl/riscv_divider.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/riscv_divider.sv
// Iterative restoring radix-2 divider for the RV64M DIV/REM family, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module riscv_divider #(
  parameter int XLEN = 64
) (
  input  logic            i_riscv_div_clk,
  input  logic            i_riscv_div_rst,
  input  logic            i_riscv_div_start,
  input  logic [2:0]      i_riscv_div_ctrl,
  input  logic [XLEN-1:0] i_riscv_div_rs1data,
  input  logic [XLEN-1:0] i_riscv_div_rs2data,
  output logic [XLEN-1:0] o_riscv_div_result,
  output logic            o_riscv_div_valid,
  output logic            o_riscv_div_busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] divisor_reg;
  logic            word_reg;
  logic            rem_op_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic [XLEN-1:0] result_reg;
  logic            valid_reg;
  logic            busy_reg;

  // Request decode (only meaningful in IDLE)
  logic            is_word, is_signed, is_rem;
  logic [XLEN-1:0] op_a, op_b, abs_a, abs_b;
  logic            a_neg, b_neg;
  logic            div_zero, overflow;
  logic [XLEN-1:0] special_result;

  always_comb begin
    is_word   = i_riscv_div_ctrl[2];
    is_rem    = i_riscv_div_ctrl[1];
    is_signed = ~i_riscv_div_ctrl[0];
    if (is_word) begin
      op_a = is_signed ? {{(XLEN-32){i_riscv_div_rs1data[31]}}, i_riscv_div_rs1data[31:0]}
                       : {{(XLEN-32){1'b0}}, i_riscv_div_rs1data[31:0]};
      op_b = is_signed ? {{(XLEN-32){i_riscv_div_rs2data[31]}}, i_riscv_div_rs2data[31:0]}
                       : {{(XLEN-32){1'b0}}, i_riscv_div_rs2data[31:0]};
    end else begin
      op_a = i_riscv_div_rs1data;
      op_b = i_riscv_div_rs2data;
    end
    a_neg = is_signed & op_a[XLEN-1];
    b_neg = is_signed & op_b[XLEN-1];
    abs_a = a_neg ? ({XLEN{1'b0}} - op_a) : op_a;
    abs_b = b_neg ? ({XLEN{1'b0}} - op_b) : op_b;

    div_zero = (op_b == {XLEN{1'b0}});
    overflow = is_signed && (op_b == {XLEN{1'b1}}) &&
               (is_word ? (op_a == {{(XLEN-31){1'b1}}, 31'b0})
                        : (op_a == {1'b1, {(XLEN-1){1'b0}}}));

    // Remainder by zero returns the dividend; word ops always sign-extend from bit 31
    if (div_zero)
      special_result = !is_rem ? {XLEN{1'b1}}
                     : (is_word ? {{(XLEN-32){i_riscv_div_rs1data[31]}}, i_riscv_div_rs1data[31:0]}
                                : i_riscv_div_rs1data);
    else
      special_result = is_rem ? {XLEN{1'b0}} : op_a;
  end

  // One restoring iteration plus the final sign fix on its outcome
  logic [XLEN:0]   rem_shift, diff;
  logic [XLEN-1:0] rem_step, quo_step;
  logic [XLEN-1:0] q_mag, q_fix, r_fix, raw_result, calc_result;
  logic [CW-1:0]   last_iter;

  always_comb begin
    rem_shift = {rem_reg, quo_reg[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor_reg};
    if (!diff[XLEN]) begin
      rem_step = diff[XLEN-1:0];
      quo_step = {quo_reg[XLEN-2:0], 1'b1};
    end else begin
      rem_step = rem_shift[XLEN-1:0];
      quo_step = {quo_reg[XLEN-2:0], 1'b0};
    end
    q_mag      = word_reg ? {{(XLEN-32){1'b0}}, quo_step[31:0]} : quo_step;
    q_fix      = neg_q_reg ? ({XLEN{1'b0}} - q_mag) : q_mag;
    r_fix      = neg_r_reg ? ({XLEN{1'b0}} - rem_step) : rem_step;
    raw_result = rem_op_reg ? r_fix : q_fix;
    calc_result = word_reg ? {{(XLEN-32){raw_result[31]}}, raw_result[31:0]} : raw_result;
    last_iter  = word_reg ? CW'(31) : CW'(XLEN-1);
  end

  always_ff @(posedge i_riscv_div_clk) begin
    if (i_riscv_div_rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          valid_reg <= 1'b0;
          if (i_riscv_div_start) begin
            word_reg    <= is_word;
            rem_op_reg  <= is_rem;
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
            divisor_reg <= abs_b;
            // Word dividends sit in the top half so 32 shifts consume exactly them
            quo_reg     <= is_word ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            if (div_zero || overflow) begin
              result_reg <= special_result;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end else begin
              state_reg  <= CALC;
            end
          end
        end
        CALC: begin
          quo_reg <= quo_step;
          rem_reg <= rem_step;
          if (cnt_reg == last_iter) begin
            cnt_reg    <= '0;
            result_reg <= calc_result;
            valid_reg  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_riscv_div_result = result_reg;
  assign o_riscv_div_valid  = valid_reg;
  assign o_riscv_div_busy   = busy_reg;

endmodule
